// File: rtl/control_hazard_pipe_if.sv
// Bundle between the decode stage and the control/hazard pipeline.
// The master side is decode plus branch resolution; the slave side is the pipeline.
interface control_hazard_pipe_if #(
  parameter int REGADDRWIDTH = 4
);
  // Decode-stage control bundle and register addresses
  logic                    validD;
  logic                    obtainPCAsR1DD;
  logic                    writeEnableDD;
  logic                    writeDataEnableMD;
  logic                    resultSelectorWBD;
  logic                    data2SelectorED;
  logic                    outFlag;
  logic [2:0]              aluControlED;
  logic [REGADDRWIDTH-1:0] rdD;
  logic [REGADDRWIDTH-1:0] rs1D;
  logic [REGADDRWIDTH-1:0] rs2D;
  logic                    branchTakenE;

  // Hazard controls back to fetch/decode
  logic                    stallF;
  logic                    stallD;
  logic                    flushD;

  // Staged controls towards the datapath
  logic                    obtainPCAsR1E;
  logic                    data2SelectorE;
  logic [2:0]              aluControlE;
  logic [1:0]              forwardAE;
  logic [1:0]              forwardBE;
  logic                    writeDataEnableM;
  logic [REGADDRWIDTH-1:0] rdM;
  logic                    writeEnableW;
  logic                    resultSelectorW;
  logic [REGADDRWIDTH-1:0] rdW;
  logic                    outFlagW;

  modport master (
    output validD, obtainPCAsR1DD, writeEnableDD, writeDataEnableMD,
           resultSelectorWBD, data2SelectorED, outFlag, aluControlED,
           rdD, rs1D, rs2D, branchTakenE,
    input  stallF, stallD, flushD, obtainPCAsR1E, data2SelectorE,
           aluControlE, forwardAE, forwardBE, writeDataEnableM, rdM,
           writeEnableW, resultSelectorW, rdW, outFlagW
  );

  modport slave (
    input  validD, obtainPCAsR1DD, writeEnableDD, writeDataEnableMD,
           resultSelectorWBD, data2SelectorED, outFlag, aluControlED,
           rdD, rs1D, rs2D, branchTakenE,
    output stallF, stallD, flushD, obtainPCAsR1E, data2SelectorE,
           aluControlE, forwardAE, forwardBE, writeDataEnableM, rdM,
           writeEnableW, resultSelectorW, rdW, outFlagW
  );
endinterface

// File: rtl/control_hazard_pipe.sv
// Control pipeline E -> M -> W with load-use stall, branch flush and
// E-stage operand forwarding selects. Bubbles carry valid=0 and all fields 0.
module control_hazard_pipe #(
  parameter int REGADDRWIDTH = 4
) (
  input logic                 clk,
  input logic                 rst,
  control_hazard_pipe_if.slave bus
);

  // E stage state
  logic                    valid_e_reg;
  logic                    pc_e_reg;
  logic                    we_e_reg;
  logic                    wdm_e_reg;
  logic                    rsel_e_reg;
  logic                    d2_e_reg;
  logic                    out_e_reg;
  logic [2:0]              alu_e_reg;
  logic [REGADDRWIDTH-1:0] rd_e_reg;
  logic [REGADDRWIDTH-1:0] rs1_e_reg;
  logic [REGADDRWIDTH-1:0] rs2_e_reg;

  // M stage state
  logic                    valid_m_reg;
  logic                    we_m_reg;
  logic                    wdm_m_reg;
  logic                    rsel_m_reg;
  logic                    out_m_reg;
  logic [REGADDRWIDTH-1:0] rd_m_reg;

  // W stage state
  logic                    valid_w_reg;
  logic                    we_w_reg;
  logic                    rsel_w_reg;
  logic                    out_w_reg;
  logic [REGADDRWIDTH-1:0] rd_w_reg;

  logic load_use;
  logic stall;
  logic e_capture;

  // A load sitting in E whose destination feeds the D instruction cannot be
  // forwarded in time, so decode must wait one cycle.
  assign load_use = valid_e_reg & we_e_reg & rsel_e_reg & bus.validD &
                    ((rd_e_reg == bus.rs1D) | (rd_e_reg == bus.rs2D));

  // A taken branch discards D anyway, so it overrides the stall.
  assign stall     = load_use & ~bus.branchTakenE;
  assign e_capture = bus.validD & ~bus.branchTakenE & ~load_use;

  assign bus.stallF = stall;
  assign bus.stallD = stall;
  assign bus.flushD = bus.branchTakenE;

  // E register: capture D, or insert a bubble on stall/flush/empty decode
  always_ff @(posedge clk) begin
    if (rst || !e_capture) begin
      valid_e_reg <= 1'b0;
      pc_e_reg    <= 1'b0;
      we_e_reg    <= 1'b0;
      wdm_e_reg   <= 1'b0;
      rsel_e_reg  <= 1'b0;
      d2_e_reg    <= 1'b0;
      out_e_reg   <= 1'b0;
      alu_e_reg   <= '0;
      rd_e_reg    <= '0;
      rs1_e_reg   <= '0;
      rs2_e_reg   <= '0;
    end else begin
      valid_e_reg <= 1'b1;
      pc_e_reg    <= bus.obtainPCAsR1DD;
      we_e_reg    <= bus.writeEnableDD;
      wdm_e_reg   <= bus.writeDataEnableMD;
      rsel_e_reg  <= bus.resultSelectorWBD;
      d2_e_reg    <= bus.data2SelectorED;
      out_e_reg   <= bus.outFlag;
      alu_e_reg   <= bus.aluControlED;
      rd_e_reg    <= bus.rdD;
      rs1_e_reg   <= bus.rs1D;
      rs2_e_reg   <= bus.rs2D;
    end
  end

  // M and W registers always advance; bubbles flow through as zeros
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_m_reg <= 1'b0;
      we_m_reg    <= 1'b0;
      wdm_m_reg   <= 1'b0;
      rsel_m_reg  <= 1'b0;
      out_m_reg   <= 1'b0;
      rd_m_reg    <= '0;
      valid_w_reg <= 1'b0;
      we_w_reg    <= 1'b0;
      rsel_w_reg  <= 1'b0;
      out_w_reg   <= 1'b0;
      rd_w_reg    <= '0;
    end else begin
      valid_m_reg <= valid_e_reg;
      we_m_reg    <= we_e_reg;
      wdm_m_reg   <= wdm_e_reg;
      rsel_m_reg  <= rsel_e_reg;
      out_m_reg   <= out_e_reg;
      rd_m_reg    <= rd_e_reg;
      valid_w_reg <= valid_m_reg;
      we_w_reg    <= we_m_reg;
      rsel_w_reg  <= rsel_m_reg;
      out_w_reg   <= out_m_reg;
      rd_w_reg    <= rd_m_reg;
    end
  end

  // Forwarding selects: index 0 is operand A (rs1), index 1 is operand B (rs2).
  // Operand A is never forwarded when it is the PC.
  logic [REGADDRWIDTH-1:0] src_e [2];
  logic [1:0]              fwd_en;
  logic [3:0]              fwd_sel;

  assign src_e[0]  = rs1_e_reg;
  assign src_e[1]  = rs2_e_reg;
  assign fwd_en[0] = valid_e_reg & ~pc_e_reg;
  assign fwd_en[1] = valid_e_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic hit_m;
      logic hit_w;
      assign hit_m = valid_m_reg & we_m_reg & (rd_m_reg == src_e[gi]);
      assign hit_w = valid_w_reg & we_w_reg & (rd_w_reg == src_e[gi]);
      assign fwd_sel[gi*2 +: 2] = !fwd_en[gi] ? 2'b00 :
                                  hit_m       ? 2'b10 :
                                  hit_w       ? 2'b01 : 2'b00;
    end
  endgenerate

  assign bus.forwardAE = fwd_sel[1:0];
  assign bus.forwardBE = fwd_sel[3:2];

  assign bus.obtainPCAsR1E    = pc_e_reg;
  assign bus.data2SelectorE   = d2_e_reg;
  assign bus.aluControlE      = alu_e_reg;
  assign bus.writeDataEnableM = valid_m_reg & wdm_m_reg;
  assign bus.rdM              = rd_m_reg;
  assign bus.writeEnableW     = valid_w_reg & we_w_reg;
  assign bus.resultSelectorW  = rsel_w_reg;
  assign bus.rdW              = rd_w_reg;
  assign bus.outFlagW         = valid_w_reg & out_w_reg;

endmodule

// File: tb/tb_control_hazard_pipe.sv
// Scoreboard bench: stimulus queues expected output values tagged with the
// cycle they must appear in; a negedge monitor pops and compares them.
module tb_control_hazard_pipe;
  localparam int AW = 4;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   passes;

  control_hazard_pipe_if #(.REGADDRWIDTH(AW)) bus ();

  control_hazard_pipe #(.REGADDRWIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {
    F_STALLF, F_STALLD, F_FLUSHD, F_PCE, F_ALUE, F_FWA, F_FWB,
    F_WDEM, F_RDM, F_WEW, F_RSW, F_RDW, F_OUTW
  } field_t;

  typedef struct {
    int     cyc;
    field_t fld;
    int     val;
    string  name;
  } exp_t;

  exp_t exp_q[$];

  function automatic int get_field(field_t f);
    case (f)
      F_STALLF: return int'(bus.stallF);
      F_STALLD: return int'(bus.stallD);
      F_FLUSHD: return int'(bus.flushD);
      F_PCE:    return int'(bus.obtainPCAsR1E);
      F_ALUE:   return int'(bus.aluControlE);
      F_FWA:    return int'(bus.forwardAE);
      F_FWB:    return int'(bus.forwardBE);
      F_WDEM:   return int'(bus.writeDataEnableM);
      F_RDM:    return int'(bus.rdM);
      F_WEW:    return int'(bus.writeEnableW);
      F_RSW:    return int'(bus.resultSelectorW);
      F_RDW:    return int'(bus.rdW);
      F_OUTW:   return int'(bus.outFlagW);
      default:  return -1;
    endcase
  endfunction

  // Monitor: compare every expectation due in the current cycle
  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        int act;
        act = get_field(exp_q[i].fld);
        checks++;
        if (act == exp_q[i].val) begin
          passes++;
          $display("cycle %0d check %s: got %0d expected %0d ok", cyc, exp_q[i].name, act, exp_q[i].val);
        end else begin
          $display("FAIL cycle %0d %s: got %0d expected %0d", cyc, exp_q[i].name, act, exp_q[i].val);
        end
        exp_q.delete(i);
      end
    end
  end

  task automatic expect_at(int c, field_t f, int v, string nm);
    exp_t e;
    e.cyc = c; e.fld = f; e.val = v; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(logic v, logic pc, logic we, logic wdm, logic rsel,
                       logic d2, logic out, logic [2:0] alu,
                       logic [AW-1:0] rd, logic [AW-1:0] rs1, logic [AW-1:0] rs2);
    bus.validD            = v;
    bus.obtainPCAsR1DD    = pc;
    bus.writeEnableDD     = we;
    bus.writeDataEnableMD = wdm;
    bus.resultSelectorWBD = rsel;
    bus.data2SelectorED   = d2;
    bus.outFlag           = out;
    bus.aluControlED      = alu;
    bus.rdD               = rd;
    bus.rs1D              = rs1;
    bus.rs2D              = rs2;
  endtask

  task automatic idle();
    set_d(0, 0, 0, 0, 0, 0, 0, 3'd0, '0, '0, '0);
  endtask

  task automatic drain();
    idle();
    repeat (4) step();
  endtask

  int t;

  initial begin
    checks = 0;
    passes = 0;
    rst = 1'b1;
    bus.branchTakenE = 1'b0;
    idle();
    repeat (2) step();

    // 1: reset state, then one write propagating E -> M -> W
    rst = 1'b0;
    t = cyc;
    checks++;
    if (bus.stallD == 1'b0) begin
      passes++;
      $display("cycle %0d check rst_stallD_direct: got %0d expected 0 ok", cyc, bus.stallD);
    end else begin
      $display("FAIL cycle %0d rst_stallD_direct: got %0d expected 0", cyc, bus.stallD);
    end
    checks++;
    if (bus.flushD == 1'b0) begin
      passes++;
      $display("cycle %0d check rst_flushD_direct: got %0d expected 0 ok", cyc, bus.flushD);
    end else begin
      $display("FAIL cycle %0d rst_flushD_direct: got %0d expected 0", cyc, bus.flushD);
    end
    checks++;
    if (bus.writeEnableW == 1'b0) begin
      passes++;
      $display("cycle %0d check rst_weW_direct: got %0d expected 0 ok", cyc, bus.writeEnableW);
    end else begin
      $display("FAIL cycle %0d rst_weW_direct: got %0d expected 0", cyc, bus.writeEnableW);
    end
    expect_at(t, F_ALUE, 0, "rst_aluE");
    expect_at(t, F_RDM, 0, "rst_rdM");
    expect_at(t, F_WEW, 0, "rst_weW");
    expect_at(t, F_OUTW, 0, "rst_outW");
    expect_at(t, F_WDEM, 0, "rst_wdeM");
    expect_at(t, F_STALLF, 0, "rst_stallF");
    set_d(1, 0, 1, 0, 0, 0, 0, 3'b101, 4'd3, 4'd0, 4'd0);
    expect_at(t + 1, F_ALUE, 5, "prop_aluE");
    expect_at(t + 2, F_RDM, 3, "prop_rdM");
    expect_at(t + 3, F_WEW, 1, "prop_weW");
    expect_at(t + 3, F_RDW, 3, "prop_rdW");
    expect_at(t + 4, F_WEW, 0, "prop_weW_once");
    step();
    drain();

    // 2: load-use stall for one cycle, consumer then forwards from W
    t = cyc;
    set_d(1, 0, 1, 0, 1, 0, 0, 3'd2, 4'd5, 4'd0, 4'd0);
    step();
    set_d(1, 0, 1, 0, 0, 0, 0, 3'd1, 4'd6, 4'd5, 4'd0);
    expect_at(t + 1, F_STALLF, 1, "lu_stallF");
    expect_at(t + 1, F_STALLD, 1, "lu_stallD");
    expect_at(t + 1, F_FLUSHD, 0, "lu_flushD");
    expect_at(t + 1, F_ALUE, 2, "lu_loadE");
    expect_at(t + 2, F_STALLF, 0, "lu_stall_end");
    expect_at(t + 2, F_ALUE, 0, "lu_bubbleE");
    expect_at(t + 2, F_RDM, 5, "lu_loadM");
    expect_at(t + 3, F_ALUE, 1, "lu_consE");
    expect_at(t + 3, F_FWA, 1, "lu_fwA");
    expect_at(t + 3, F_FWB, 0, "lu_fwB");
    expect_at(t + 3, F_RSW, 1, "lu_rselW");
    step();
    step();
    drain();

    // 3a: back-to-back writes to r2, consumer reads r2 twice -> M wins
    t = cyc;
    set_d(1, 0, 1, 0, 0, 0, 0, 3'd1, 4'd2, 4'd0, 4'd0);
    step();
    set_d(1, 0, 1, 0, 0, 0, 0, 3'd3, 4'd2, 4'd0, 4'd0);
    step();
    set_d(1, 0, 1, 0, 0, 0, 0, 3'd4, 4'd9, 4'd2, 4'd2);
    expect_at(t + 2, F_STALLF, 0, "fp_nostall");
    expect_at(t + 3, F_ALUE, 4, "fp_consE");
    expect_at(t + 3, F_FWA, 2, "fp_fwA_M");
    expect_at(t + 3, F_FWB, 2, "fp_fwB_M");
    step();
    drain();

    // 3b: one unrelated instruction between second write and consumer -> W
    t = cyc;
    set_d(1, 0, 1, 0, 0, 0, 0, 3'd1, 4'd2, 4'd0, 4'd0);
    step();
    set_d(1, 0, 1, 0, 0, 0, 0, 3'd3, 4'd2, 4'd0, 4'd0);
    step();
    set_d(1, 0, 1, 0, 0, 0, 0, 3'd7, 4'd8, 4'd1, 4'd1);
    step();
    set_d(1, 0, 1, 0, 0, 0, 0, 3'd4, 4'd9, 4'd2, 4'd2);
    expect_at(t + 4, F_FWA, 1, "fp_fwA_W");
    expect_at(t + 4, F_FWB, 1, "fp_fwB_W");
    step();
    drain();

    // 4: taken branch in the same cycle as a load-use condition
    t = cyc;
    set_d(1, 0, 1, 0, 1, 0, 0, 3'd2, 4'd5, 4'd0, 4'd0);
    step();
    set_d(1, 0, 1, 0, 0, 0, 0, 3'd1, 4'd6, 4'd5, 4'd0);
    bus.branchTakenE = 1'b1;
    #1;
    checks++;
    if (bus.flushD == 1'b1) begin
      passes++;
      $display("cycle %0d check fl_flushD_direct: got %0d expected 1 ok", cyc, bus.flushD);
    end else begin
      $display("FAIL cycle %0d fl_flushD_direct: got %0d expected 1", cyc, bus.flushD);
    end
    checks++;
    if (bus.stallF == 1'b0) begin
      passes++;
      $display("cycle %0d check fl_stallF_direct: got %0d expected 0 ok", cyc, bus.stallF);
    end else begin
      $display("FAIL cycle %0d fl_stallF_direct: got %0d expected 0", cyc, bus.stallF);
    end
    expect_at(t + 1, F_FLUSHD, 1, "fl_flushD");
    expect_at(t + 1, F_STALLF, 0, "fl_stallF");
    expect_at(t + 1, F_STALLD, 0, "fl_stallD");
    expect_at(t + 2, F_ALUE, 0, "fl_bubbleE");
    expect_at(t + 2, F_RDM, 5, "fl_branchM");
    expect_at(t + 3, F_ALUE, 0, "fl_discarded");
    step();
    bus.branchTakenE = 1'b0;
    drain();

    // 5: PC as operand A suppresses forwarding on A only
    t = cyc;
    set_d(1, 0, 1, 0, 0, 0, 0, 3'd1, 4'd7, 4'd0, 4'd0);
    step();
    set_d(1, 1, 1, 0, 0, 0, 0, 3'd6, 4'd1, 4'd7, 4'd7);
    expect_at(t + 2, F_PCE, 1, "pc_pcE");
    expect_at(t + 2, F_ALUE, 6, "pc_aluE");
    expect_at(t + 2, F_FWA, 0, "pc_fwA");
    expect_at(t + 2, F_FWB, 2, "pc_fwB");
    step();
    drain();

    // 6: reset with three valid writes (store + output) in flight
    t = cyc;
    set_d(1, 0, 1, 1, 0, 0, 1, 3'd1, 4'd1, 4'd0, 4'd0);
    step();
    set_d(1, 0, 1, 1, 0, 0, 1, 3'd1, 4'd2, 4'd0, 4'd0);
    step();
    set_d(1, 0, 1, 1, 0, 0, 1, 3'd1, 4'd3, 4'd0, 4'd0);
    step();
    idle();
    rst = 1'b1;
    expect_at(t + 3, F_WEW, 1, "mr_pre_weW");
    expect_at(t + 3, F_OUTW, 1, "mr_pre_outW");
    expect_at(t + 3, F_WDEM, 1, "mr_pre_wdeM");
    for (int k = 4; k <= 6; k++) begin
      expect_at(t + k, F_WEW, 0, "mr_weW");
      expect_at(t + k, F_WDEM, 0, "mr_wdeM");
      expect_at(t + k, F_OUTW, 0, "mr_outW");
    end
    step();
    rst = 1'b0;
    repeat (5) step();

    // Any expectation never reached by the monitor is a failure
    while (exp_q.size() > 0) begin
      checks++;
      $display("FAIL unchecked %s: due cycle %0d, never compared (now %0d)", exp_q[0].name, exp_q[0].cyc, cyc);
      exp_q.delete(0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
